session_timer_ctrl: RTL

SESSION_TIMER_CTRL -- requirements
Module: session_timer_ctrl

---
 rtl/session_timer_if.sv | 22 ++
 rtl/session_timer_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/session_timer_if.sv
// Session timer bus: the button/LED master drives requests,
// the timer slave returns session status and pulses.
interface session_timer_if;
  logic       start;
  logic [1:0] mode;
  logic       abort;
  logic       timer_end;
  logic       mini_rst;
  logic [7:0] secs_left;
  logic       running;
  logic       busy;

  modport master (
    output start, mode, abort,
    input  timer_end, mini_rst, secs_left, running, busy
  );

  modport slave (
    input  start, mode, abort,
    output timer_end, mini_rst, secs_left, running, busy
  );
endinterface

// File: rtl/session_timer_ctrl.sv
// Session countdown timer: IDLE -> ARM -> RUN -> DONE.
// Optional RUN/PAUSE toggle on start edges with SESSION_PAUSE_EN.
module session_timer_ctrl #(
  parameter int unsigned TICK_DIV = 100000000,
  parameter logic [7:0]  DUR0     = 8'd30,
  parameter logic [7:0]  DUR1     = 8'd60,
  parameter logic [7:0]  DUR2     = 8'd90,
  parameter logic [7:0]  DUR3     = 8'd120
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  session_timer_if.slave  bus
);

  localparam int unsigned   PW   = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PONE = PW'(1);

`ifdef SESSION_PAUSE_EN
  typedef enum logic [2:0] {
    IDLE, ARM, RUN, DONE, PAUSE
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, ARM, RUN, DONE
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [7:0]    secs_q, secs_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    mode_q, mode_d;
  logic          start_q;
  logic          live_q;
  logic          te_q, mr_q, run_q, busy_q;
  logic          start_edge;
  logic          tick;
  logic [7:0]    dur_raw, dur_sel;

  // live_q masks the first cycle after reset so a held start is no edge
  assign start_edge = bus.start & ~start_q & live_q;
  assign tick       = (presc_q == PMAX);

  always_comb begin
    dur_raw = DUR0;
    case (mode_q)
      2'b00:   dur_raw = DUR0;
      2'b01:   dur_raw = DUR1;
      2'b10:   dur_raw = DUR2;
      default: dur_raw = DUR3;
    endcase
    dur_sel = (dur_raw == 8'd0) ? 8'd1 : dur_raw;
  end

  always_comb begin
    state_d = state_q;
    secs_d  = secs_q;
    presc_d = presc_q;
    mode_d  = mode_q;
    if (state_q != IDLE && bus.abort) begin
      state_d = IDLE;
      secs_d  = 8'd0;
      presc_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_edge && !bus.abort) begin
            mode_d  = bus.mode;
            presc_d = '0;
            state_d = ARM;
          end
        end
        // ARM is prescaler count 0 of the first second
        ARM: begin
          secs_d  = dur_sel;
          presc_d = PONE;
          state_d = RUN;
        end
        RUN: begin
`ifdef SESSION_PAUSE_EN
          if (start_edge) begin
            state_d = PAUSE;
          end else
`endif
          if (tick) begin
            presc_d = '0;
            if (secs_q <= 8'd1) begin
              secs_d  = 8'd0;
              state_d = DONE;
            end else begin
              secs_d = secs_q - 8'd1;
            end
          end else begin
            presc_d = presc_q + PONE;
          end
        end
        DONE: state_d = IDLE;
`ifdef SESSION_PAUSE_EN
        PAUSE: begin
          if (start_edge) state_d = RUN;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q <= IDLE;
      secs_q  <= 8'd0;
      presc_q <= '0;
      mode_q  <= 2'b00;
      start_q <= 1'b0;
      live_q  <= 1'b0;
      te_q    <= 1'b0;
      mr_q    <= 1'b0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      secs_q  <= secs_d;
      presc_q <= presc_d;
      mode_q  <= mode_d;
      start_q <= bus.start;
      live_q  <= 1'b1;
      te_q    <= (state_d == DONE);
      mr_q    <= (state_d == ARM);
      run_q   <= (state_d == RUN);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.timer_end = te_q;
  assign bus.mini_rst  = mr_q;
  assign bus.running   = run_q;
  assign bus.busy      = busy_q;
  assign bus.secs_left = secs_q;

endmodule
